// File: rtl/rank_filter_3x3_if.sv
// -----------------------------------------------------------------------------
// rank_filter_3x3_if
//   Pixel stream bundle shared by the input and output side of the 3x3
//   rank-order filter: frame sync, line sync, pixel qualifier and pixel data.
//
//   vsync  frame sync, high for the duration of a frame
//   hsync  line sync, high for the duration of a line
//   valid  pixel qualifier, one pixel per high cycle
//   data   pixel value, DATA_W bits, unsigned
//
//   master : the side that drives the stream
//   slave  : the side that consumes the stream
// -----------------------------------------------------------------------------
interface rank_filter_3x3_if #(
  parameter int DATA_W = 8
);
  logic              vsync;
  logic              hsync;
  logic              valid;
  logic [DATA_W-1:0] data;

  modport master (
    output vsync,
    output hsync,
    output valid,
    output data
  );

  modport slave (
    input vsync,
    input hsync,
    input valid,
    input data
  );
endinterface

// File: rtl/rank_filter_3x3.sv
// -----------------------------------------------------------------------------
// rank_filter_3x3
//   Parametrised 3x3 rank-order filter for a single-channel video stream.
//   Two line buffers plus three 3-deep shift registers form a trailing 3x3
//   window (output for input (r,c) filters pixels (r-2..r, c-2..c)). A
//   pipelined compare network yields the median, minimum or maximum of the
//   window; a bypass mode passes the newest pixel through untouched.
//   Fixed latency of 5 clocks; sync signals are delayed to match.
//
// Parameters
//   DATA_W  pixel width in bits
//   IMG_W   maximum active pixels per line (line-buffer depth)
//   COL_AW  line-buffer address width
//
// Ports
//   clk        pixel clock
//   rst        asynchronous active-high reset
//   mode       0 median, 1 min, 2 max, 3 bypass (latched at vsync rise)
//   edge_mode  border output: 0 newest pixel, 1 zero (latched with mode)
//   pre_img    input stream  (vsync/hsync/valid/data)
//   post_img   output stream (vsync/hsync/valid/data), delayed by 5 clocks
// -----------------------------------------------------------------------------
module rank_filter_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 1024,
  parameter int COL_AW = $clog2(IMG_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                edge_mode,
  rank_filter_3x3_if.slave    pre_img,
  rank_filter_3x3_if.master   post_img
);

  localparam int L = 5;
  // One extra bit so the column counter can hold IMG_W itself (saturation).
  localparam int CNT_W = COL_AW + 1;
  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_W);

  localparam logic [1:0] MODE_MED    = 2'd0;
  localparam logic [1:0] MODE_MIN    = 2'd1;
  localparam logic [1:0] MODE_MAX    = 2'd2;
  localparam logic [1:0] MODE_BYPASS = 2'd3;

  typedef logic [DATA_W-1:0] pix_t;

  // ---------------------------------------------------------------------------
  // Compare helpers (unsigned, ties allowed, result is always an input)
  // ---------------------------------------------------------------------------
  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    return max2(max2(a, b), c);
  endfunction

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    return min2(min2(a, b), c);
  endfunction

  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  // ---------------------------------------------------------------------------
  // Sync edge detection, counters, frame registers
  // ---------------------------------------------------------------------------
  logic             vsync_d, hsync_d;
  logic             vs_rise, hs_rise, hs_fall;
  logic [CNT_W-1:0] col_q, col_e, col_n;
  logic [1:0]       row_q, row_e, row_n;
  logic             armed_q, armed_e;
  logic [1:0]       mode_q, mode_e;
  logic             em_q, em_e;
  logic             in_rng, border, beat;

  assign vs_rise = pre_img.vsync & ~vsync_d;
  assign hs_rise = pre_img.hsync & ~hsync_d;
  assign hs_fall = ~pre_img.hsync & hsync_d;
  assign beat    = pre_img.valid;

  // Events in the current clock take effect for the beat in the same clock:
  // a line start sees col 0, a frame start sees row 0 and the new frame mode.
  always_comb begin
    col_e   = hs_rise ? '0 : col_q;
    row_e   = vs_rise ? '0 : row_q;
    armed_e = armed_q | vs_rise;
    mode_e  = vs_rise ? mode : mode_q;
    em_e    = vs_rise ? edge_mode : em_q;
    in_rng  = (col_e != COL_MAX);
    border  = (row_e < 2'd2) | (col_e < CNT_W'(2)) | ~in_rng | ~armed_e;
  end

  always_comb begin
    col_n = col_e;
    if (beat && in_rng)
      col_n = col_e + CNT_W'(1);
    // A beat coincident with the hsync fall still used row_q above.
    row_n = row_e;
    if (!vs_rise && hs_fall && row_q != 2'd3)
      row_n = row_q + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // vsync_d resets high so a vsync that is already high when reset
      // releases is not mistaken for a frame start; the frame stays unarmed
      // until a genuine low-to-high transition.
      vsync_d <= 1'b1;
      hsync_d <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      armed_q <= 1'b0;
      mode_q  <= MODE_MED;
      em_q    <= 1'b0;
    end else begin
      vsync_d <= pre_img.vsync;
      hsync_d <= pre_img.hsync;
      col_q   <= col_n;
      row_q   <= row_n;
      armed_q <= armed_e;
      mode_q  <= mode_e;
      em_q    <= em_e;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: buf0 holds line r-1, buf1 holds line r-2 at each column.
  // ---------------------------------------------------------------------------
  pix_t              buf0 [IMG_W];
  pix_t              buf1 [IMG_W];
  logic [COL_AW-1:0] addr;
  pix_t              rd0, rd1;

  assign addr = in_rng ? col_e[COL_AW-1:0] : '0;
  assign rd0  = in_rng ? buf0[addr] : '0;
  assign rd1  = in_rng ? buf1[addr] : '0;

  always_ff @(posedge clk) begin
    if (beat && in_rng) begin
      buf0[addr] <= pre_img.data;
      buf1[addr] <= buf0[addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0: window capture (rows r-2, r-1, r; column index 2 is newest)
  // ---------------------------------------------------------------------------
  pix_t       win_p0 [3][3];
  logic       vld_p0, bord_p0, em_p0;
  logic [1:0] mode_p0;
  pix_t       pix_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 3; j++)
          win_p0[k][j] <= '0;
      vld_p0  <= 1'b0;
      bord_p0 <= 1'b0;
      em_p0   <= 1'b0;
      mode_p0 <= MODE_MED;
      pix_p0  <= '0;
    end else begin
      if (beat) begin
        for (int k = 0; k < 3; k++) begin
          win_p0[k][0] <= win_p0[k][1];
          win_p0[k][1] <= win_p0[k][2];
        end
        win_p0[0][2] <= rd1;
        win_p0[1][2] <= rd0;
        win_p0[2][2] <= pre_img.data;
        pix_p0       <= pre_img.data;
      end
      vld_p0  <= beat;
      bord_p0 <= border;
      em_p0   <= em_e;
      mode_p0 <= mode_e;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: sort each window row into max / med / min
  // ---------------------------------------------------------------------------
  pix_t       mx_p1 [3];
  pix_t       md_p1 [3];
  pix_t       mn_p1 [3];
  logic       vld_p1, bord_p1, em_p1;
  logic [1:0] mode_p1;
  pix_t       pix_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        mx_p1[k] <= '0;
        md_p1[k] <= '0;
        mn_p1[k] <= '0;
      end
      vld_p1  <= 1'b0;
      bord_p1 <= 1'b0;
      em_p1   <= 1'b0;
      mode_p1 <= MODE_MED;
      pix_p1  <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        mx_p1[k] <= max3(win_p0[k][0], win_p0[k][1], win_p0[k][2]);
        md_p1[k] <= med3(win_p0[k][0], win_p0[k][1], win_p0[k][2]);
        mn_p1[k] <= min3(win_p0[k][0], win_p0[k][1], win_p0[k][2]);
      end
      vld_p1  <= vld_p0;
      bord_p1 <= bord_p0;
      em_p1   <= em_p0;
      mode_p1 <= mode_p0;
      pix_p1  <= pix_p0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: column combine. The median of the window is the median of
  // {min of row maxes, med of row meds, max of row mins}.
  // ---------------------------------------------------------------------------
  pix_t       lo_p2, mid_p2, hi_p2, min_p2, max_p2;
  logic       vld_p2, bord_p2, em_p2;
  logic [1:0] mode_p2;
  pix_t       pix_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_p2   <= '0;
      mid_p2  <= '0;
      hi_p2   <= '0;
      min_p2  <= '0;
      max_p2  <= '0;
      vld_p2  <= 1'b0;
      bord_p2 <= 1'b0;
      em_p2   <= 1'b0;
      mode_p2 <= MODE_MED;
      pix_p2  <= '0;
    end else begin
      lo_p2   <= max3(mn_p1[0], mn_p1[1], mn_p1[2]);
      mid_p2  <= med3(md_p1[0], md_p1[1], md_p1[2]);
      hi_p2   <= min3(mx_p1[0], mx_p1[1], mx_p1[2]);
      min_p2  <= min3(mn_p1[0], mn_p1[1], mn_p1[2]);
      max_p2  <= max3(mx_p1[0], mx_p1[1], mx_p1[2]);
      vld_p2  <= vld_p1;
      bord_p2 <= bord_p1;
      em_p2   <= em_p1;
      mode_p2 <= mode_p1;
      pix_p2  <= pix_p1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p3: final select (bypass ignores border substitution)
  // ---------------------------------------------------------------------------
  pix_t sel_p2;
  pix_t res_p3;
  logic vld_p3;

  always_comb begin
    sel_p2 = pix_p2;
    if (mode_p2 == MODE_BYPASS) begin
      sel_p2 = pix_p2;
    end else if (bord_p2) begin
      sel_p2 = em_p2 ? '0 : pix_p2;
    end else begin
      case (mode_p2)
        MODE_MED: sel_p2 = med3(lo_p2, mid_p2, hi_p2);
        MODE_MIN: sel_p2 = min_p2;
        MODE_MAX: sel_p2 = max_p2;
        default:  sel_p2 = pix_p2;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_p3 <= '0;
      vld_p3 <= 1'b0;
    end else begin
      res_p3 <= sel_p2;
      vld_p3 <= vld_p2;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p4: output register; data holds its last value between beats
  // ---------------------------------------------------------------------------
  pix_t         data_p4;
  logic         vld_p4;
  logic [L-1:0] vs_sr, hs_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p4 <= '0;
      vld_p4  <= 1'b0;
      vs_sr   <= '0;
      hs_sr   <= '0;
    end else begin
      if (vld_p3)
        data_p4 <= res_p3;
      vld_p4 <= vld_p3;
      vs_sr  <= {vs_sr[L-2:0], pre_img.vsync};
      hs_sr  <= {hs_sr[L-2:0], pre_img.hsync};
    end
  end

  assign post_img.vsync = vs_sr[L-1];
  assign post_img.hsync = hs_sr[L-1];
  assign post_img.valid = vld_p4;
  assign post_img.data  = data_p4;

endmodule

// File: tb/tb_rank_filter_3x3.sv
// -----------------------------------------------------------------------------
// tb_rank_filter_3x3
//   Directed bench for rank_filter_3x3 (IMG_W = 8). Frames are driven from an
//   image array; each input beat enqueues its expected output (computed from
//   the 2D image by a sort-based model) and the cycle it was driven. A monitor
//   on the falling edge pops the queue on every output beat, checks the pixel
//   and the 5-cycle latency, and records the output by (row, col) so the
//   hand-computed values can be checked per frame.
// -----------------------------------------------------------------------------
module tb_rank_filter_3x3;

  localparam int DW = 8;
  localparam int IW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       edge_mode;

  rank_filter_3x3_if #(.DATA_W(DW)) pre_if ();
  rank_filter_3x3_if #(.DATA_W(DW)) post_if ();

  rank_filter_3x3 #(
    .DATA_W (DW),
    .IMG_W  (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .edge_mode (edge_mode),
    .pre_img   (pre_if),
    .post_img  (post_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int r;
    int c;
    int exp;
    int cyc;
  } beat_t;

  beat_t exp_q[$];
  int    img     [0:7][0:11];
  int    out_img [0:7][0:11];
  int    fmode;
  int    fem;
  bit    armed_m;

  // Reference: sort the nine window pixels straight from the image.
  function automatic int model(input int r, input int c);
    int v [9];
    int t;
    int pix;
    pix = img[r][c];
    if (fmode == 3) return pix;
    if (r < 2 || c < 2 || c >= IW || !armed_m) return (fem != 0) ? 0 : pix;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[i*3+j] = img[r-2+i][c-2+j];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    case (fmode)
      0:       return v[4];
      1:       return v[0];
      default: return v[8];
    endcase
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (post_if.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("pix(%0d,%0d)", e.r, e.c), post_if.data, e.exp);
        check($sformatf("lat(%0d,%0d)", e.r, e.c), cyc - e.cyc, 5);
        out_img[e.r][e.c] = int'(post_if.data);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_out();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 12; c++)
        out_img[r][c] = -1;
  endtask

  task automatic send_frame(input int nr, input int nc, input int mode_f, input int em_f,
                            input bit gaps, input int rst_row, input int tog_row);
    beat_t b;
    clr_out();
    for (int r = 0; r < nr; r++) begin
      if (r == rst_row) begin
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_valid", post_if.valid, 0);
        check("rst_mid_data", post_if.data, 0);
        check("rst_mid_vsync", post_if.vsync, 0);
        exp_q.delete();
        armed_m = 1'b0;
        fmode   = 0;
        fem     = 0;
        tick();
        rst = 1'b0;
      end
      if (r == tog_row) mode = 2'd2;
      for (int c = 0; c < nc; c++) begin
        tick();
        if (r == 0 && c == 0) begin
          mode          = 2'(mode_f);
          edge_mode     = 1'(em_f);
          fmode         = mode_f;
          fem           = em_f;
          armed_m       = 1'b1;
          pre_if.vsync  = 1'b1;
        end
        pre_if.hsync = 1'b1;
        pre_if.valid = 1'b1;
        pre_if.data  = 8'(img[r][c]);
        b.r   = r;
        b.c   = c;
        b.exp = model(r, c);
        b.cyc = cyc;
        exp_q.push_back(b);
        if (gaps && $urandom_range(0, 2) == 0) begin
          tick();
          pre_if.valid = 1'b0;
        end
      end
      tick();
      pre_if.valid = 1'b0;
      pre_if.hsync = 1'b0;
      tick();
    end
    tick();
    pre_if.vsync = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    rst          = 1'b1;
    mode         = 2'd0;
    edge_mode    = 1'b0;
    pre_if.vsync = 1'b0;
    pre_if.hsync = 1'b0;
    pre_if.valid = 1'b0;
    pre_if.data  = '0;
    fmode        = 0;
    fem          = 0;
    armed_m      = 1'b0;
    repeat (3) tick();
    check("reset_valid", post_if.valid, 0);
    check("reset_vsync", post_if.vsync, 0);
    check("reset_hsync", post_if.hsync, 0);
    check("reset_data", post_if.data, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Flat frame with one bright pixel.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 12; c++)
        img[r][c] = 20;
    img[4][4] = 255;

    send_frame(8, 8, 0, 0, 1'b0, -1, -1);
    check("med_55", out_img[5][5], 20);
    check("med_44", out_img[4][4], 20);
    check("med_border_03", out_img[0][3], 20);
    check("med_border_41", out_img[4][1], 20);

    send_frame(8, 8, 1, 0, 1'b1, -1, -1);
    check("min_44", out_img[4][4], 20);
    check("min_55", out_img[5][5], 20);
    check("min_66", out_img[6][6], 20);

    send_frame(8, 8, 2, 0, 1'b0, -1, -1);
    check("max_44", out_img[4][4], 255);
    check("max_55", out_img[5][5], 255);
    check("max_66", out_img[6][6], 255);
    check("max_64", out_img[6][4], 255);
    check("max_34", out_img[3][4], 20);
    check("max_47", out_img[4][7], 20);
    check("max_77", out_img[7][7], 20);

    // Single 3x3 window.
    img[0][0] = 10; img[0][1] = 90; img[0][2] = 30;
    img[1][0] = 70; img[1][1] = 50; img[1][2] = 20;
    img[2][0] = 80; img[2][1] = 40; img[2][2] = 60;
    send_frame(3, 3, 0, 0, 1'b0, -1, -1);
    check("win_med", out_img[2][2], 50);
    send_frame(3, 3, 1, 0, 1'b0, -1, -1);
    check("win_min", out_img[2][2], 10);
    send_frame(3, 3, 2, 0, 1'b0, -1, -1);
    check("win_max", out_img[2][2], 90);
    send_frame(3, 3, 3, 1, 1'b0, -1, -1);
    check("win_bypass", out_img[2][2], 60);
    check("bypass_border", out_img[0][0], 10);

    // Ramp, zero borders, mode input changed mid-frame.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 12; c++)
        img[r][c] = r * 10 + c;
    send_frame(6, 6, 0, 1, 1'b0, -1, 3);
    check("em1_00", out_img[0][0], 0);
    check("em1_15", out_img[1][5], 0);
    check("em1_51", out_img[5][1], 0);
    check("ramp_med_33", out_img[3][3], 22);
    check("tog_ignored_55", out_img[5][5], 44);
    send_frame(6, 6, 2, 1, 1'b0, -1, -1);
    check("tog_next_22", out_img[2][2], 22);
    check("tog_next_55", out_img[5][5], 55);
    check("tog_next_02", out_img[0][2], 0);

    // Reset pulse in row 4, then a clean frame.
    send_frame(8, 8, 0, 1, 1'b0, 4, -1);
    check("post_rst_55", out_img[5][5], 55);
    check("post_rst_40", out_img[4][0], 40);
    send_frame(8, 8, 0, 0, 1'b0, -1, -1);
    check("rearm_22", out_img[2][2], 11);
    check("rearm_05", out_img[0][5], 5);
    check("rearm_77", out_img[7][7], 66);

    // Over-long lines with valid gaps.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 12; c++)
        img[r][c] = int'($urandom_range(0, 255));
    send_frame(4, 12, 0, 1, 1'b1, -1, -1);
    for (int c = 8; c < 12; c++)
      check($sformatf("long_border_3_%0d", c), out_img[3][c], 0);
    check("long_border_21", out_img[2][1], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
